spi_boot_streamer: RTL and testbench

//  SPI master that streams a boot image into the SPI RAM loader debug port
//  (sclk/cs_n/mosi) of the subservient SoC. Accepts image bytes on a

---
 rtl/spi_boot_streamer_pkg.sv | 23 ++
 rtl/spi_boot_tick.sv | 37 +++
 rtl/spi_boot_streamer.sv | 147 ++++++++++++++
 tb/tb_spi_boot_streamer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_boot_streamer_pkg.sv
// Shared definitions for the SPI boot streamer: FSM state encoding,
// byte/bit-counter widths and a helper to size the half-period divider.
package spi_boot_streamer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    localparam int         STATE_W   = 3;
    localparam int         BYTE_W    = 8;
    localparam int         BIT_CNT_W = 3;
    localparam logic [2:0] LAST_BIT  = 3'd7;

    // Divider counter width; a divide-by-one still needs a 1-bit register.
    function automatic int div_cnt_w(input int div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/spi_boot_tick.sv
// Half-period divider for the SPI boot streamer. Counts 0..CLK_DIV-1 while
// enabled and flags the last count as a tick; clears when disabled or on i_clr.
module spi_boot_tick
    import spi_boot_streamer_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int               CNT_W    = div_cnt_w(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Free-running half-period counter, held at zero whenever not timing a state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_r <= '0;
        end else if (i_clr || !i_en) begin
            cnt_r <= '0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Tick is a pure decode of the counter register, so it cannot glitch.
    assign o_tick = i_en && (cnt_r == CNT_LAST);

endmodule

// File: rtl/spi_boot_streamer.sv
// SPI mode-0 master that streams a boot image (valid/ready byte stream) into
// the SoC's SPI RAM loader port, MSB first, one cs_n frame per image.
module spi_boot_streamer
    import spi_boot_streamer_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic [7:0]       i_tdata,
    input  logic             i_tvalid,
    output logic             o_tready,
    output logic             o_sclk,
    output logic             o_cs_n,
    output logic             o_mosi,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t                 state_r;
    logic [LEN_W-1:0]       rem_r;
    logic [BYTE_W-1:0]      shreg_r;
    logic [BIT_CNT_W-1:0]   bit_cnt_r;
    logic                   sclk_r;
    logic                   cs_n_r;
    logic                   mosi_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   tick_s;
    logic                   en_s;
    logic                   clr_s;

    // The divider only runs in the timed states. It is held clear in IDLE and
    // LOAD, and every exit from a timed state happens on a tick (counter wrap),
    // so each state is entered with the divider at zero.
    assign en_s  = (state_r == ST_SETUP) || (state_r == ST_SHIFT) || (state_r == ST_HOLD);
    assign clr_s = (state_r == ST_IDLE) || (state_r == ST_LOAD);

    spi_boot_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (en_s),
        .i_clr   (clr_s),
        .o_tick  (tick_s)
    );

    // Frame FSM with the shift register, counters and all SPI pins registered.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            rem_r     <= '0;
            shreg_r   <= 8'h00;
            bit_cnt_r <= 3'd0;
            sclk_r    <= 1'b0;
            cs_n_r    <= 1'b1;
            mosi_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    sclk_r <= 1'b0;
                    if (i_start) begin
                        if (i_len != '0) begin
                            state_r <= ST_SETUP;
                            cs_n_r  <= 1'b0;
                            busy_r  <= 1'b1;
                            rem_r   <= i_len;
                        end else begin
                            // Empty image: report completion without opening a frame.
                            done_r <= 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (tick_s) begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    sclk_r <= 1'b0;
                    if (i_tvalid) begin
                        shreg_r   <= i_tdata;
                        mosi_r    <= i_tdata[7];
                        bit_cnt_r <= 3'd0;
                        state_r   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick_s) begin
                        if (!sclk_r) begin
                            // Rising edge: loader samples, mosi stays put.
                            sclk_r <= 1'b1;
                        end else begin
                            sclk_r <= 1'b0;
                            if (bit_cnt_r == LAST_BIT) begin
                                rem_r <= rem_r - LEN_ONE;
                                if (rem_r == LEN_ONE) begin
                                    state_r <= ST_HOLD;
                                end else begin
                                    state_r <= ST_LOAD;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                                shreg_r   <= {shreg_r[6:0], 1'b0};
                                mosi_r    <= shreg_r[6];
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    sclk_r <= 1'b0;
                    if (tick_s) begin
                        cs_n_r  <= 1'b1;
                        mosi_r  <= 1'b0;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    sclk_r  <= 1'b0;
                    cs_n_r  <= 1'b1;
                    mosi_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tready = (state_r == ST_LOAD);
    assign o_sclk   = sclk_r;
    assign o_cs_n   = cs_n_r;
    assign o_mosi   = mosi_r;
    assign o_busy   = busy_r;
    assign o_done   = done_r;

endmodule

// File: tb/tb_spi_boot_streamer.sv
// Self-checking bench for spi_boot_streamer: two instances (CLK_DIV=2 and
// CLK_DIV=1), directed frames, and a mode-0 slave monitor acting as scoreboard.
module tb_spi_boot_streamer;

    localparam int LEN_W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_n_v  = 2'b00;
    logic [1:0]       start_v  = 2'b00;
    logic [1:0]       tvalid_v = 2'b00;
    logic [LEN_W-1:0] len_v   [2];
    logic [7:0]       tdata_v [2];
    logic [1:0]       tready_w, sclk_w, cs_w, mosi_w, busy_w, done_w;

    spi_boot_streamer #(.CLK_DIV(2), .LEN_W(LEN_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n_v[0]), .i_start(start_v[0]), .i_len(len_v[0]),
        .i_tdata(tdata_v[0]), .i_tvalid(tvalid_v[0]), .o_tready(tready_w[0]),
        .o_sclk(sclk_w[0]), .o_cs_n(cs_w[0]), .o_mosi(mosi_w[0]),
        .o_busy(busy_w[0]), .o_done(done_w[0])
    );

    spi_boot_streamer #(.CLK_DIV(1), .LEN_W(LEN_W)) dut_div1 (
        .i_clk(clk), .i_rst_n(rst_n_v[1]), .i_start(start_v[1]), .i_len(len_v[1]),
        .i_tdata(tdata_v[1]), .i_tvalid(tvalid_v[1]), .o_tready(tready_w[1]),
        .o_sclk(sclk_w[1]), .o_cs_n(cs_w[1]), .o_mosi(mosi_w[1]),
        .o_busy(busy_w[1]), .o_done(done_w[1])
    );

    int checks = 0;
    int errors = 0;
    int div_of [2] = '{2, 1};

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    int         rise_total [2] = '{0, 0};
    int         done_total [2] = '{0, 0};
    int         bitc       [2] = '{0, 0};
    int         last_rise  [2] = '{0, 0};
    logic [7:0] shr        [2];
    logic       prev_sclk  [2] = '{1'b0, 1'b0};
    int         cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Mode-0 slave model: sample mosi on each rising sclk inside a frame.
    task automatic mon_step(input int d);
        logic [7:0] e;
        if (cs_w[d] !== 1'b0) begin
            bitc[d] = 0;
        end else if (sclk_w[d] === 1'b1 && prev_sclk[d] === 1'b0) begin
            rise_total[d]++;
            if (bitc[d] != 0)
                check($sformatf("sclk_period_d%0d", d), cyc - last_rise[d], 2 * div_of[d]);
            last_rise[d] = cyc;
            shr[d] = {shr[d][6:0], mosi_w[d]};
            bitc[d]++;
            if (bitc[d] == 8) begin
                bitc[d] = 0;
                if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte_d%0d: got %02h expected none", d, shr[d]);
                end else begin
                    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    check($sformatf("spi_byte_d%0d", d), shr[d], e);
                end
            end
        end
        if (done_w[d] === 1'b1) done_total[d]++;
        prev_sclk[d] = sclk_w[d];
    endtask

    always @(negedge clk) begin
        cyc++;
        mon_step(0);
        mon_step(1);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int d);
        int k = 0;
        while (tready_w[d] !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        if (tready_w[d] !== 1'b1) check($sformatf("tready_timeout_d%0d", d), 0, 1);
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, input bit push);
        tdata_v[d]  = b;
        tvalid_v[d] = 1'b1;
        if (push) begin
            if (d == 0) exp_q0.push_back(b);
            else        exp_q1.push_back(b);
        end
        wait_ready(d);
        step();
        tvalid_v[d] = 1'b0;
        tdata_v[d]  = 8'h00;
    endtask

    task automatic wait_done(input int d);
        int k = 0;
        while (done_w[d] !== 1'b1 && k < 2000) begin
            step();
            k++;
        end
        check($sformatf("done_seen_d%0d", d), done_w[d], 1'b1);
        check($sformatf("busy_at_done_d%0d", d), busy_w[d], 1'b0);
        check($sformatf("cs_n_at_done_d%0d", d), cs_w[d], 1'b1);
        step();
        check($sformatf("done_one_cycle_d%0d", d), done_w[d], 1'b0);
    endtask

    task automatic start_frame(input int d, input logic [LEN_W-1:0] n);
        start_v[d] = 1'b1;
        len_v[d]   = n;
        step();
        start_v[d] = 1'b0;
    endtask

    task automatic run_frame(input int d, input int n, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2, input int stall_idx);
        logic [7:0] bv [3];
        int r0 = rise_total[d];
        int d0 = done_total[d];
        bv[0] = b0; bv[1] = b1; bv[2] = b2;
        start_frame(d, LEN_W'(n));
        check("busy_after_start", busy_w[d], 1'b1);
        check("cs_n_after_start", cs_w[d], 1'b0);
        for (int i = 0; i < n; i++) begin
            if (i == stall_idx) begin
                wait_ready(d);
                for (int s = 0; s < 10; s++) begin
                    step();
                    check("stall_sclk_low", sclk_w[d], 1'b0);
                    check("stall_cs_n_low", cs_w[d], 1'b0);
                end
            end
            send_byte(d, bv[i], 1'b1);
        end
        wait_done(d);
        check("rise_count", rise_total[d] - r0, 8 * n);
        check("done_count", done_total[d] - d0, 1);
        check("queue_empty", (d == 0) ? exp_q0.size() : exp_q1.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        bit saw_bad;
        len_v[0] = '0; len_v[1] = '0;
        tdata_v[0] = 8'h00; tdata_v[1] = 8'h00;

        // 1: reset values
        rst_n_v = 2'b00;
        repeat (3) step();
        for (int d = 0; d < 2; d++) begin
            check("rst_sclk", sclk_w[d], 1'b0);
            check("rst_cs_n", cs_w[d], 1'b1);
            check("rst_mosi", mosi_w[d], 1'b0);
            check("rst_tready", tready_w[d], 1'b0);
            check("rst_busy", busy_w[d], 1'b0);
            check("rst_done", done_w[d], 1'b0);
        end
        rst_n_v = 2'b11;
        step();

        // 2: single byte 0xA5
        run_frame(0, 1, 8'hA5, 8'h00, 8'h00, -1);
        repeat (3) step();

        // 3: three bytes with a stall before the second
        run_frame(0, 3, 8'h00, 8'hFF, 8'h3C, 1);
        repeat (3) step();

        // 4: zero-length start
        d0 = done_total[0];
        start_frame(0, '0);
        check("len0_done", done_w[0], 1'b1);
        check("len0_cs_n", cs_w[0], 1'b1);
        check("len0_tready", tready_w[0], 1'b0);
        check("len0_busy", busy_w[0], 1'b0);
        saw_bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (cs_w[0] !== 1'b1 || tready_w[0] !== 1'b0 || done_w[0] !== 1'b0) saw_bad = 1'b1;
        end
        check("len0_quiet_after", saw_bad, 1'b0);
        check("len0_done_count", done_total[0] - d0, 1);

        // 5: reset in the middle of byte 2 of a 4-byte frame
        start_frame(0, 16'd4);
        send_byte(0, 8'h12, 1'b1);
        send_byte(0, 8'h34, 1'b0);
        repeat (10) step();
        d0 = done_total[0];
        rst_n_v[0] = 1'b0;
        step();
        check("abort_cs_n", cs_w[0], 1'b1);
        check("abort_sclk", sclk_w[0], 1'b0);
        check("abort_busy", busy_w[0], 1'b0);
        check("abort_done", done_w[0], 1'b0);
        check("abort_tready", tready_w[0], 1'b0);
        repeat (2) step();
        rst_n_v[0] = 1'b1;
        repeat (3) step();
        check("abort_no_done", done_total[0] - d0, 0);
        check("abort_queue", exp_q0.size(), 0);
        run_frame(0, 2, 8'hC6, 8'h01, 8'h00, -1);

        // 6: CLK_DIV=1, second start during a frame is ignored
        d0 = done_total[1];
        begin
            int r0 = rise_total[1];
            start_frame(1, 16'd2);
            check("d1_busy", busy_w[1], 1'b1);
            send_byte(1, 8'h5A, 1'b1);
            start_frame(1, 16'd5);
            send_byte(1, 8'hC3, 1'b1);
            wait_done(1);
            check("d1_rise_count", rise_total[1] - r0, 16);
            repeat (20) step();
            check("d1_done_count", done_total[1] - d0, 1);
            check("d1_cs_n_idle", cs_w[1], 1'b1);
            check("d1_busy_idle", busy_w[1], 1'b0);
            check("d1_queue", exp_q1.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
